// File: rtl/reset_seq_ctrl.sv
// Sequences async preset/clear lines for a bank of flop domains: assert per mask,
// hold, then release one domain per clock so every release is synchronous to clk.

module reset_seq_dom #(
  parameter bit RST_PRESET = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic assert_en,
  input  logic assert_preset,
  input  logic release_en,
  output logic preset_n,
  output logic clr
);
  // Only one of preset_n/clr is ever driven low, so the downstream flop sees a clean
  // set or clear and never both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preset_n <= ~RST_PRESET;
      clr      <= RST_PRESET;
    end else if (assert_en) begin
      preset_n <= ~assert_preset;
      clr      <= assert_preset;
    end else if (release_en) begin
      preset_n <= 1'b1;
      clr      <= 1'b1;
    end
  end
endmodule

module reset_seq_ctrl #(
  parameter int                     NUM_DOMAINS = 4,
  parameter int                     HOLD_CYCLES = 8,
  parameter int                     SYNC_STAGES = 2,
  parameter logic [NUM_DOMAINS-1:0] RESET_MASK  = {NUM_DOMAINS{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_req,
  input  logic [NUM_DOMAINS-1:0] sw_mask,
  output logic [NUM_DOMAINS-1:0] preset_n,
  output logic [NUM_DOMAINS-1:0] clr,
  output logic                   ready,
  output logic [7:0]             done_cnt
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, READY} state_t;

  state_t                   state, state_nx;
  logic [SYNC_STAGES-1:0]   sync_q, sync_nx;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [NUM_DOMAINS-1:0]   mask_q;
  logic [NUM_DOMAINS-1:0]   assert_mask;
  logic [NUM_DOMAINS-1:0]   rel;
  logic                     sync_enter, hold_done, last_rel, accept, assert_en;

  if (SYNC_STAGES == 1) begin : g_sync1
    assign sync_nx = 1'b1;
  end else begin : g_syncn
    assign sync_nx = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_enter = sync_nx[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1];
  assign hold_done  = (state == HOLD) && (cnt == CW'(HOLD_CYCLES - 1));
  assign last_rel   = (state == RELEASE) && (idx == IW'(NUM_DOMAINS - 1));
  assign accept     = (state == READY) && sw_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SYNC:    if (sync_enter) state_nx = HOLD;
      HOLD:    if (hold_done)  state_nx = RELEASE;
      RELEASE: if (last_rel)   state_nx = READY;
      READY:   if (sw_req)     state_nx = HOLD;
      default: state_nx = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt      <= '0;
      idx      <= '0;
      mask_q   <= RESET_MASK;
      ready    <= 1'b0;
      done_cnt <= 8'd0;
    end else begin
      sync_q <= sync_nx;
      case (state)
        SYNC: if (sync_enter) cnt <= '0;
        HOLD: begin
          cnt <= cnt + 1'b1;
          if (hold_done) idx <= '0;
        end
        RELEASE: begin
          idx <= idx + 1'b1;
          if (last_rel) begin
            ready <= 1'b1;
            if (done_cnt != 8'hFF) done_cnt <= done_cnt + 8'd1;
          end
        end
        READY: if (sw_req) begin
          mask_q <= sw_mask;
          ready  <= 1'b0;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  // The accepting edge loads sw_mask directly; during HOLD the domains are refreshed
  // from the captured mask so the asserted polarity cannot drift.
  assign assert_en   = accept || (state == HOLD);
  assign assert_mask = accept ? sw_mask : mask_q;

  always_comb begin
    rel = '0;
    for (int i = 0; i < NUM_DOMAINS; i++)
      rel[i] = (state == RELEASE) && (idx == IW'(i));
  end

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    reset_seq_dom #(.RST_PRESET(RESET_MASK[g])) u_dom (
      .clk          (clk),
      .rst          (rst),
      .assert_en    (assert_en),
      .assert_preset(assert_mask[g]),
      .release_en   (rel[g]),
      .preset_n     (preset_n[g]),
      .clr          (clr[g])
    );
  end
endmodule

// File: doc/reset_seq_ctrl.md
# reset_seq_ctrl

Sequencer that drives the asynchronous preset/clear inputs of a bank of `NUM_DOMAINS` downstream flop groups. Each group uses active-low `preset_n` and active-low `clr`. On system reset or on software request, the block asserts exactly one of preset or clear per domain and holds it for a programmable time. It then releases the domains one per clock in index order, so no downstream flop ever sees a release asynchronous to `clk`. It sits between the global reset input and the register banks built from our async-preset/clear flops.

## Interface
- `NUM_DOMAINS`, 4: number of controlled domains, ≥1.
- `HOLD_CYCLES`, 8: clocks the assert condition is held before release begins, ≥1.
- `SYNC_STAGES`, 2: reset-deassertion synchronizer depth, ≥1.
- `RESET_MASK`, {NUM_DOMAINS{1'b0}}: per-domain select applied on hardware reset; 1 = preset, 0 = clear.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw_req`  in  1  software re-init request; level, sampled only in READY.
- `sw_mask`  in  NUM_DOMAINS  preset/clear select used for a software re-init; captured with `sw_req`.
- `preset_n`  out  NUM_DOMAINS  per-domain active-low preset, registered.
- `clr`  out  NUM_DOMAINS  per-domain active-low clear, registered.
- `ready`  out  1  high when every domain is released.
- `done_cnt`  out  8  completed sequences, saturating.

## Operation
- States: SYNC, HOLD, RELEASE, READY. Internal registers: `mask_q`, hold counter `cnt`, release index `idx`, synchronizer shift register.

While `rst` is high (takes effect immediately, asynchronously):
- state=SYNC, synchronizer=0, cnt=0, idx=0.
- mask_q=RESET_MASK.
- For domain i: `preset_n[i]`=~RESET_MASK[i], `clr[i]`=RESET_MASK[i].
- ready=0, done_cnt=0.

State transitions:
- SYNC: the synchronizer shifts in 1 each edge. On the edge where the last stage becomes 1 (edge `SYNC_STAGES` after `rst` falls), go to HOLD with cnt=0.
- HOLD: cnt increments each edge. On the edge where cnt==HOLD_CYCLES-1, go to RELEASE with idx=0.
- RELEASE: each edge sets `preset_n[idx]`=1 and `clr[idx]`=1, then idx+1.
  - On the edge that releases domain NUM_DOMAINS-1, go to READY.
  - On that same edge set ready=1 and done_cnt+1, saturating at 255.
- READY: if `sw_req`=1 at an edge:
  - mask_q=sw_mask;
  - every domain is re-asserted per sw_mask: `preset_n[i]`=~sw_mask[i], `clr[i]`=sw_mask[i];
  - ready=0, cnt=0, state=HOLD.

Rules:
- Per domain, `preset_n` and `clr` are never low at the same time. Exactly one of them is low while the domain is asserted.
- `sw_req` is ignored outside READY; there is no queueing.
- If `sw_req` is held high, the sequence restarts on the first edge after each return to READY.
- `sw_mask` is ignored except on the accepting edge.
- A `rst` assertion in any state aborts the sequence and immediately produces the reset values. Domains already released re-assert asynchronously.
- Released domains stay released until the next `rst` or accepted `sw_req`.

## Timing
- Let E be the edge on which HOLD is entered. RELEASE is entered at E+HOLD_CYCLES; domain i is released at edge E+HOLD_CYCLES+1+i; `ready` rises with the last release at E+HOLD_CYCLES+NUM_DOMAINS.
- Hardware reset: E=SYNC_STAGES, counted from the first edge after `rst` falls (edge 1). With defaults, domain 0 releases at edge 11 and domain 3 plus `ready` at edge 14.
- Software re-init: E is the accepting edge (edge 0). With defaults, outputs re-assert after edge 0, domain 0 releases at edge 9, and `ready` rises at edge 12.
- Minimum assert width per domain: HOLD_CYCLES+1+i clocks.
- All outputs are flop-driven, with no combinational path from inputs. `rst` is the only asynchronous path.

## Test plan
- Hardware reset, defaults, RESET_MASK=4'b0101, `rst` held 3 cycles then dropped:
  - during reset, preset_n=4'b1010 and clr=4'b0101;
  - after edge 11, preset_n=4'b1011; after edge 12, clr=4'b0111; after edge 14, all ones, ready=1, done_cnt=1.
- Software re-init from READY with sw_mask=4'b1100 and a 1-cycle `sw_req`:
  - after edge 0, preset_n=4'b0011, clr=4'b1100, ready=0;
  - releases follow at edges 9, 10, 11, 12; ready=1 after edge 12; done_cnt=2.
- `sw_req` pulsed during HOLD and RELEASE: no effect on timing or mask; sequence completes at the nominal edge; done_cnt increments once.
- `rst` asserted mid-RELEASE after domains 0–1 are released: all outputs return to RESET_MASK values without waiting for a clock edge; done_cnt=0; a full 14-edge sequence follows.
- `sw_req` held high for 100 cycles from READY: back-to-back sequences of 13 cycles each; every edge checks that no domain has preset_n=0 and clr=0 at once; done_cnt counts up and, in a long run, saturates at 255.
